playback_controller: RTL and testbench
======================================

// Module: playback_controller
// PURPOSE
//  Step-timing engine downstream of the input interface. Consumes BPM, Loops and Start; on Start,
//  latches tempo and loop count, derives the step period with a sequential divider, and emits one
//  StepTick per step over STEPS steps per loop for Loops loops. Drives play_en back to the input
//  interface (low => it leaves play mode). Step/StepTick feed the pattern memory and audio stages.
// PARAMETERS
//  CLK_HZ          50_000_000  system clock frequency
//  STEPS           16          steps per loop (power of two)
//  STEPS_PER_BEAT  4           steps per BPM beat
// PORTS
//  CLOCK_50   in   1              system clock
//  nReset     in   1              reset, asynchronous, active-low
//  BPM        in   10             tempo, beats/min; sampled only on Start edge
//  Loops      in   7              loops to play; sampled only on Start edge
//  Start      in   1              play request; rising edge acts (pulse or level)
//  Abort      in   1              stop request, 1-cycle pulse
//  play_en    out  1              high while playback is calculating or running
//  StepTick   out  1              1-cycle pulse at start of every step
//  Step       out  $clog2(STEPS)  current step index
//  LoopsLeft  out  7              loops remaining, including current
//  Done       out  1              1-cycle pulse on normal completion
// BEHAVIOUR
//  Reset (async, nReset=0): state IDLE; all outputs 0; latched BPM/Loops/counters 0.
//  Start edge = Start & ~start_q (start_q registered, reset 0). Acted on in IDLE only.
//  States: IDLE -> CALC -> RUN -> IDLE.
//  IDLE: edge with BPM!=0 and Loops!=0 -> CALC; latch BPM, LoopsLeft<=Loops; launch divider;
//    play_en=1 from next cycle. Edge with BPM==0 or Loops==0 ignored (no output change).
//  CALC: divider computes PERIOD = NUM / BPM_latched, NUM = CLK_HZ*60/STEPS_PER_BEAT
//    (750_000_000 default); 32-bit unsigned, quotient truncated; quotient 0 clamps to 1.
//    On divider done -> RUN next cycle with Step=0, StepTick=1 that cycle, cycle counter=0.
//  RUN: counter increments each cycle; at counter==PERIOD-1: counter<=0 and
//    - Step<STEPS-1: Step+1, StepTick=1.
//    - Step==STEPS-1, LoopsLeft>1: Step wraps to 0, LoopsLeft-1, StepTick=1.
//    - Step==STEPS-1, LoopsLeft==1: -> IDLE; play_en=0, Done=1 (one cycle), LoopsLeft=0,
//      Step=0, no StepTick.
//  Abort in CALC or RUN: -> IDLE next cycle, play_en=0, Step=0, LoopsLeft=0, no Done, no
//    StepTick; divider result discarded. Abort in IDLE ignored. Abort beats a same-cycle step end.
//  Start edge while in CALC/RUN ignored; BPM/Loops changes during playback have no effect.
//  Step period exact: ticks exactly PERIOD cycles apart, including across loop wrap.
//  All outputs registered; no combinational input-to-output paths.
// STRUCTURE
//  Shared package: NUM constant derivation, state encoding (one-hot IDLE/CALC/RUN, 3 bits),
//    DIV_W=32.
//  Sub-module seq_divider: restoring radix-2, DIV_W cycles; ports Clock, nReset, start,
//    dividend, divisor, busy, done (1-cycle pulse), quotient. Divisor never 0 (guarded).
// TESTING  (bench: CLK_HZ=1200, STEPS=4, STEPS_PER_BEAT=4 -> NUM=18000)
//  Reset mid-RUN -> all outputs 0 immediately (async), IDLE, later Start edge works normally.
//  BPM=60, Loops=2, Start pulse -> play_en high next cycle; PERIOD=300; 8 StepTicks 300 cycles
//    apart, Step 0,1,2,3,0,1,2,3, LoopsLeft 2->1 at wrap; then Done pulse, play_en=0.
//  BPM=0 or Loops=0, Start -> no play_en, no StepTick, outputs unchanged.
//  BPM=120, Loops=5, Abort at 2nd step -> IDLE next cycle, no Done, LoopsLeft=0.
//  Start held high 1000 cycles, BPM changed 60->90 mid-run -> single run, PERIOD stays 300.
//  BPM=1023, NUM=18000 -> PERIOD=17; BPM=1023 with CLK_HZ=60 (NUM=900) -> quotient 0 clamped,
//    StepTick every cycle.

Source files
------------

// File: rtl/playback_controller_pkg.sv
// rtl/playback_controller_pkg.sv - shared constants, state encoding and divider width for playback_controller
package playback_controller_pkg;

    localparam int DIV_W = 32;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_CALC = 3'b010;
    localparam logic [2:0] ST_RUN  = 3'b100;

    // Clock cycles per minute divided by steps per beat; divided by BPM this gives cycles per step.
    function automatic logic [DIV_W-1:0] calc_num(input longint unsigned clk_hz,
                                                  input longint unsigned steps_per_beat);
        return DIV_W'((clk_hz * 64'd60) / steps_per_beat);
    endfunction

endpackage

// File: rtl/playback_controller_seq_divider.sv
// rtl/playback_controller_seq_divider.sv - restoring radix-2 sequential divider, one quotient bit per cycle
module seq_divider
    import playback_controller_pkg::*;
(
    input  logic             Clock,
    input  logic             nReset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int CW = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [DIV_W:0]   shifted, diff;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[DIV_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        // A new start always restarts, so a discarded computation never leaks a done pulse.
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(DIV_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!diff[DIV_W]) begin
                rem_d = diff[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = shifted[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/playback_controller.sv
// rtl/playback_controller.sv - step-timing engine: tempo division, step ticks, loop counting, abort
module playback_controller
    import playback_controller_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS          = 16,
    parameter int STEPS_PER_BEAT = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     nReset,
    input  logic [9:0]               BPM,
    input  logic [6:0]               Loops,
    input  logic                     Start,
    input  logic                     Abort,
    output logic                     play_en,
    output logic                     StepTick,
    output logic [$clog2(STEPS)-1:0] Step,
    output logic [6:0]               LoopsLeft,
    output logic                     Done
);

    localparam int               SW        = $clog2(STEPS);
    localparam logic [DIV_W-1:0] NUM       = calc_num(CLK_HZ, STEPS_PER_BEAT);
    localparam logic [SW-1:0]    LAST_STEP = SW'(STEPS - 1);

    logic [2:0]       state_q, state_d;
    logic             start_q, start_d;
    logic [6:0]       loops_left_q, loops_left_d;
    logic [SW-1:0]    step_q, step_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             play_en_q, play_en_d, step_tick_q, step_tick_d, done_q, done_d;

    logic             start_edge, div_start, div_busy, div_done;
    logic [DIV_W-1:0] div_quotient;

    seq_divider u_div (
        .Clock   (CLOCK_50),
        .nReset  (nReset),
        .start   (div_start),
        .dividend(NUM),
        .divisor (DIV_W'(BPM)),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quotient)
    );

    always_comb begin
        state_d      = state_q;
        start_d      = Start;
        loops_left_d = loops_left_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        play_en_d    = play_en_q;
        step_tick_d  = 1'b0;
        done_d       = 1'b0;
        div_start    = 1'b0;
        start_edge   = Start & ~start_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge && BPM != 10'd0 && Loops != 7'd0) begin
                    state_d      = ST_CALC;
                    loops_left_d = Loops;
                    play_en_d    = 1'b1;
                    div_start    = 1'b1;
                end
            end
            ST_CALC: begin
                if (Abort) begin
                    state_d      = ST_IDLE;
                    play_en_d    = 1'b0;
                    step_d       = '0;
                    loops_left_d = '0;
                    cnt_d        = '0;
                end else if (div_done && !div_busy) begin
                    state_d     = ST_RUN;
                    step_d      = '0;
                    step_tick_d = 1'b1;
                    cnt_d       = '0;
                    period_d    = (div_quotient == '0) ? DIV_W'(1) : div_quotient;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    state_d      = ST_IDLE;
                    play_en_d    = 1'b0;
                    step_d       = '0;
                    loops_left_d = '0;
                    cnt_d        = '0;
                end else if (cnt_q == period_q - DIV_W'(1)) begin
                    cnt_d = '0;
                    if (step_q != LAST_STEP) begin
                        step_d      = step_q + SW'(1);
                        step_tick_d = 1'b1;
                    end else if (loops_left_q > 7'd1) begin
                        step_d       = '0;
                        loops_left_d = loops_left_q - 7'd1;
                        step_tick_d  = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        play_en_d    = 1'b0;
                        done_d       = 1'b1;
                        loops_left_d = '0;
                        step_d       = '0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            loops_left_q <= '0;
            step_q       <= '0;
            cnt_q        <= '0;
            period_q     <= '0;
            play_en_q    <= 1'b0;
            step_tick_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            loops_left_q <= loops_left_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            play_en_q    <= play_en_d;
            step_tick_q  <= step_tick_d;
            done_q       <= done_d;
        end
    end

    assign play_en   = play_en_q;
    assign StepTick  = step_tick_q;
    assign Step      = step_q;
    assign LoopsLeft = loops_left_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_playback_controller.sv
// tb/tb_playback_controller.sv - randomized self-checking bench for playback_controller
module tb_playback_controller;

    localparam int STEPS = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] bpm;
    logic [6:0] loops;
    logic       start, abort;

    logic       a_play, a_tick, a_done, b_play, b_tick, b_done;
    logic [1:0] a_step, b_step;
    logic [6:0] a_ll, b_ll;

    logic       sel;
    logic       m_play, m_tick, m_done;
    logic [1:0] m_step;
    logic [6:0] m_ll;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    playback_controller #(.CLK_HZ(1200), .STEPS(4), .STEPS_PER_BEAT(4)) dut_a (
        .CLOCK_50(clk), .nReset(rst_n), .BPM(bpm), .Loops(loops), .Start(start), .Abort(abort),
        .play_en(a_play), .StepTick(a_tick), .Step(a_step), .LoopsLeft(a_ll), .Done(a_done)
    );

    playback_controller #(.CLK_HZ(60), .STEPS(4), .STEPS_PER_BEAT(4)) dut_b (
        .CLOCK_50(clk), .nReset(rst_n), .BPM(bpm), .Loops(loops), .Start(start), .Abort(abort),
        .play_en(b_play), .StepTick(b_tick), .Step(b_step), .LoopsLeft(b_ll), .Done(b_done)
    );

    always_comb begin
        m_play = sel ? b_play : a_play;
        m_tick = sel ? b_tick : a_tick;
        m_done = sel ? b_done : a_done;
        m_step = sel ? b_step : a_step;
        m_ll   = sel ? b_ll   : a_ll;
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bpm = '0; loops = '0; start = 1'b0; abort = 1'b0; sel = 1'b0;
        cyc1(); cyc1();
        checks++;
        if ({a_play, a_tick, a_step, a_ll, a_done} !== 12'd0)
            $display("FAIL reset_outputs got=%h exp=0", {a_play, a_tick, a_step, a_ll, a_done});
        rst_n = 1'b1;
        cyc1(); cyc1();
        checks++;
        if ({a_play, a_tick, a_step, a_ll, a_done} !== 12'd0)
            $display("FAIL idle_after_reset got=%h exp=0", {a_play, a_tick, a_step, a_ll, a_done});
    endtask

    // Reference: period = max(1, NUM/BPM); tick n shows Step n%STEPS and LoopsLeft loops-n/STEPS.
    task automatic run_play(input int bpm_v, input int loops_v, input bit use_b,
                            input int abort_at, input int hold, input int bpm_new);
        int num, per, nexp, n, last_t, budget, c, dones;
        bit fin, quiet;
        num  = use_b ? 900 : 18000;
        per  = num / bpm_v;
        if (per == 0) per = 1;
        nexp = (abort_at >= 0) ? abort_at + 1 : STEPS * loops_v;
        sel  = use_b;
        bpm  = bpm_v[9:0]; loops = loops_v[6:0]; start = 1'b1;
        cyc1(); c = 1;
        checks++;
        if (m_play !== 1'b1) begin errors++; $display("FAIL play_en_rise got=%b exp=1", m_play); end
        if (hold <= 1) start = 1'b0;
        n = 0; dones = 0; fin = 0; last_t = 0;
        budget = 80 + per * STEPS * loops_v;
        while (!fin && c < budget) begin
            cyc1(); c++;
            if (c >= hold) start = 1'b0;
            if (c == 200 && bpm_new >= 0) bpm = bpm_new[9:0];
            if (m_tick) begin
                checks++;
                if (m_step !== 2'(n % STEPS)) begin
                    errors++; $display("FAIL step_index tick=%0d got=%0d exp=%0d", n, m_step, n % STEPS);
                end
                checks++;
                if (m_ll !== 7'(loops_v - n / STEPS)) begin
                    errors++; $display("FAIL loops_left tick=%0d got=%0d exp=%0d", n, m_ll, loops_v - n / STEPS);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_t != per) begin
                        errors++; $display("FAIL tick_period tick=%0d got=%0d exp=%0d", n, cyc - last_t, per);
                    end
                end
                last_t = cyc;
                n++;
                if (n - 1 == abort_at) begin
                    abort = 1'b1;
                    cyc1(); c++;
                    abort = 1'b0;
                    checks++;
                    if ({m_play, m_tick, m_step, m_ll, m_done} !== 12'd0) begin
                        errors++;
                        $display("FAIL abort_outputs got=%h exp=0", {m_play, m_tick, m_step, m_ll, m_done});
                    end
                    fin = 1;
                end
            end
            if (m_done) begin
                dones++;
                checks++;
                if ({m_play, m_tick, m_step, m_ll} !== 11'd0 || cyc - last_t != per) begin
                    errors++;
                    $display("FAIL done_state got=%h gap=%0d exp=0 gap=%0d", {m_play, m_tick, m_step, m_ll}, cyc - last_t, per);
                end
                fin = 1;
            end
        end
        start = 1'b0;
        checks++;
        if (!fin) begin errors++; $display("FAIL run_timeout got=%0d exp<%0d cycles", c, budget); end
        checks++;
        if (n != nexp) begin errors++; $display("FAIL tick_count got=%0d exp=%0d", n, nexp); end
        checks++;
        if (dones != ((abort_at >= 0) ? 0 : 1)) begin
            errors++; $display("FAIL done_count got=%0d exp=%0d", dones, (abort_at >= 0) ? 0 : 1);
        end
        quiet = 1;
        repeat (20) begin
            cyc1();
            if (m_play || m_tick || m_done) quiet = 0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL quiet_after_run got=active exp=idle"); end
    endtask

    task automatic test_ignored(input int bpm_v, input int loops_v);
        bit quiet;
        sel = 1'b0;
        bpm = bpm_v[9:0]; loops = loops_v[6:0]; start = 1'b1;
        cyc1();
        start = 1'b0;
        quiet = 1;
        repeat (50) begin
            if ({a_play, a_tick, a_step, a_ll, a_done} !== 12'd0) quiet = 0;
            cyc1();
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL ignored_start bpm=%0d loops=%0d got=active exp=idle", bpm_v, loops_v); end
    endtask

    task automatic test_reset_mid_run();
        sel = 1'b0;
        bpm = 10'd120; loops = 7'd5; start = 1'b1;
        cyc1();
        start = 1'b0;
        repeat (300) cyc1();
        checks++;
        if (a_play !== 1'b1) begin errors++; $display("FAIL pre_reset_running got=%b exp=1", a_play); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_play, a_tick, a_step, a_ll, a_done} !== 12'd0) begin
            errors++; $display("FAIL async_reset got=%h exp=0", {a_play, a_tick, a_step, a_ll, a_done});
        end
        #1 rst_n = 1'b1;
        cyc1(); cyc1();
        run_play(120, 1, 1'b0, -1, 1, -1);
    endtask

    initial begin
        test_reset();
        run_play(60, 2, 1'b0, -1, 1, -1);
        test_ignored(0, 3);
        test_ignored(60, 0);
        run_play(120, 5, 1'b0, 1, 1, -1);
        run_play(60, 1, 1'b0, -1, 1000, 90);
        test_reset_mid_run();
        run_play(1023, 2, 1'b0, -1, 1, -1);
        repeat (4) begin
            int rb, rl, ra;
            rb = $urandom_range(200, 1023);
            rl = $urandom_range(1, 3);
            ra = ($urandom_range(0, 2) == 0) ? $urandom_range(0, STEPS * rl - 1) : -1;
            run_play(rb, rl, 1'b0, ra, 1, -1);
        end
        run_play(1023, 2, 1'b1, -1, 1, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
